pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Holds the architectural PC and fetches the instruction at that PC from instruction memory.
- Uses a valid/ready request channel and a valid-only response channel.
- Presents the fetched instruction to decode.
- Loads the NPC module's result when the instruction retires.
- Detects misaligned next-PC and instruction-memory timeout as sticky faults.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
TIMEOUT, 255, max cycles in S_WAIT without a response before fault (1..255, 8-bit counter).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
npc  in  32  next PC from NPC module (PC+4 or PC+IMMEXT per PCSrc).
pc  out  32  current PC, drives NPC.PC.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_addr  out  32  fetch address, equals pc.
imem_rsp_valid  in  1  response data valid.
imem_rsp_data  in  32  instruction word.
inst_valid  out  1  inst holds a fetched instruction.
inst  out  32  instruction to decode.
inst_ready  in  1  core retires inst this cycle.
fault  out  1  sticky fault flag.
fault_cause  out  2  0 none, 1 misaligned npc, 2 timeout.
retire_count  out  32  retired-instruction counter.

Behaviour:
Reset values (rst_n low, async):
- pc=RESET_PC, state=S_IDLE.
- imem_req_valid=0, inst_valid=0, inst=0.
- fault=0, fault_cause=0, retire_count=0, timeout counter=0.

States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT. All outputs are decoded from registered state or are registers.
- S_IDLE -> S_REQ on the first rising edge with rst_n high.
- S_REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready=1 -> S_WAIT and clear the counter. Otherwise hold; request and address stay stable.
- S_WAIT: the counter increments each cycle without a response.
  - imem_rsp_valid=1: inst<=imem_rsp_data and -> S_HOLD, so inst_valid is 1 the next cycle.
  - Counter reaches TIMEOUT-1 with no response: -> S_FAULT, fault_cause=2.
  - Response and timeout in the same cycle: the response wins.
- S_HOLD: inst_valid=1, inst stable. On inst_ready=1:
  - pc<=npc and retire_count+=1 (wraps at 2^32).
  - If npc[1:0]!=0 -> S_FAULT, fault_cause=1 (pc still loads npc for debug).
  - Else -> S_REQ.
- S_FAULT: fault=1, imem_req_valid=0, inst_valid=0. Stays here until reset; all inputs are ignored.

Further rules:
- At most one outstanding request.
- imem_rsp_valid outside S_WAIT is ignored.
- inst_ready outside S_HOLD is ignored.
- pc changes only on a retire in S_HOLD.
- PC arithmetic wraps mod 2^32: npc=0 after pc=32'hFFFFFFFC is a legal aligned fetch.
- Minimum retire-to-retire period is 3 cycles: S_HOLD -> S_REQ -> S_WAIT -> S_HOLD, with ready and response each in one cycle.
- Reset asserted in any state returns immediately to the reset values; an in-flight response after reset release is dropped.

Decomposition:
- Shared define.v gains the state encodings FETCH_IDLE/REQ/WAIT/HOLD/FAULT (3-bit) and FAULT_NONE/MISALIGN/TIMEOUT (2-bit), next to the PC_NOJUMP/PC_J_OFFSET PCSrc constants.
- One natural sub-module: fetch_timeout_ctr (8-bit counter with clear, enable, and expiry compare).
- The top level instantiates it and owns the FSM, pc, inst, and retire_count.

Test Plan:
1. Reset and first fetch: release rst_n, imem_req_ready=1, response 2 cycles later with 32'h00500093 -> imem_addr=0, inst_valid=1 with inst=32'h00500093, pc=0, retire_count=0.
2. Sequential retire with an NPC instance (PCSrc=PC_NOJUMP) in the loop: pc=32'h1000, inst_ready pulse -> pc=32'h1004, next imem_addr=32'h1004, retire_count=1.
3. Branch with PCSrc=PC_J_OFFSET, IMMEXT=32'hFFFFFFF0, pc=32'h3000 -> retire loads pc=32'h2FF0 and the next request targets 32'h2FF0.
4. Backpressure: imem_req_ready low for 5 cycles -> imem_req_valid stays 1 with imem_addr stable; no timeout is counted in S_REQ.
5. Timeout: TIMEOUT=8, no response -> fault=1, fault_cause=2 exactly 8 cycles after acceptance. Also drive a response on the expiry cycle -> no fault, inst captured.
6. Misaligned/wrap: npc=32'h2002 on retire -> fault_cause=1, no further requests. After reset, pc=32'hFFFFFFFC with PC_NOJUMP retire -> pc=0, fault=0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types for the PC fetch unit: FSM state encodings, fault causes and
// the PCSrc selector used by the NPC module that closes the PC loop.
package pc_fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_TIMEOUT  = 2'd2
    } fault_cause_t;

    typedef enum logic {
        PC_NOJUMP   = 1'b0,
        PC_J_OFFSET = 1'b1
    } pcsrc_t;

    // Instructions are word aligned; only the two low address bits matter.
    function automatic logic pc_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory channel: valid/ready request, valid-only response.
interface pc_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/pc_fetch_unit_timeout_ctr.sv
// 8-bit response-wait counter; expired flags the last permitted wait cycle.
module fetch_timeout_ctr #(
    parameter logic [7:0] LIMIT = 8'd254
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count_r;

    // Wait-cycle counter: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC holder and single-outstanding instruction fetcher with
// sticky misalignment / memory-timeout fault detection.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_unit_if.master  imem,
    input  logic [31:0]      npc,
    output logic [31:0]      pc,
    output logic             inst_valid,
    output logic [31:0]      inst,
    input  logic             inst_ready,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [31:0]      retire_count
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT - 32'd1);

    fetch_state_t state_r, state_s;
    fault_cause_t fault_cause_r, cause_s;
    logic [31:0]  pc_r, inst_r, retire_count_r;
    logic         ctr_clr_s, ctr_en_s, capture_s, retire_s, expired_s;

    fetch_timeout_ctr #(.LIMIT(TMO_LIMIT)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ctr_clr_s),
        .en      (ctr_en_s),
        .expired (expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath strobes; a response beats a same-cycle timeout.
    always_comb begin
        state_s   = state_r;
        cause_s   = fault_cause_r;
        ctr_clr_s = 1'b0;
        ctr_en_s  = 1'b0;
        capture_s = 1'b0;
        retire_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                state_s = S_REQ;
            end
            S_REQ: begin
                if (imem.imem_req_ready) begin
                    state_s   = S_WAIT;
                    ctr_clr_s = 1'b1;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    capture_s = 1'b1;
                    state_s   = S_HOLD;
                end else if (expired_s) begin
                    state_s = S_FAULT;
                    cause_s = FAULT_TIMEOUT;
                end else begin
                    ctr_en_s = 1'b1;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    retire_s = 1'b1;
                    if (pc_misaligned(npc[1:0])) begin
                        state_s = S_FAULT;
                        cause_s = FAULT_MISALIGN;
                    end else begin
                        state_s = S_REQ;
                    end
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_FAULT: begin
                state_s = S_FAULT;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // PC, instruction, retire counter and fault cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r           <= RESET_PC;
            inst_r         <= 32'h0000_0000;
            retire_count_r <= 32'h0000_0000;
            fault_cause_r  <= FAULT_NONE;
        end else begin
            // A misaligned npc is still loaded so debug can see where it went.
            if (retire_s) begin
                pc_r           <= npc;
                retire_count_r <= retire_count_r + 32'd1;
            end else begin
                pc_r           <= pc_r;
                retire_count_r <= retire_count_r;
            end
            if (capture_s) begin
                inst_r <= imem.imem_rsp_data;
            end else begin
                inst_r <= inst_r;
            end
            fault_cause_r <= cause_s;
        end
    end

    assign imem.imem_req_valid = (state_r == S_REQ);
    assign imem.imem_addr      = pc_r;
    assign pc                  = pc_r;
    assign inst_valid          = (state_r == S_HOLD);
    assign inst                = inst_r;
    assign fault               = (state_r == S_FAULT);
    assign fault_cause         = fault_cause_r;
    assign retire_count        = retire_count_r;

endmodule
